// File: rtl/life_engine.sv
// Game of Life generation engine for a 16x16 toroidal board.
// Holds the committed cell map, applies cursor edits and computes one generation per step.
module life_engine #(
  parameter int GEN_W = 16,
  parameter int POP_W = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step,
  input  logic             toggle,
  input  logic             clear,
  input  logic [3:0]       cursor_x,
  input  logic [3:0]       cursor_y,
  input  logic [3:0]       rd_row,
  output logic [15:0]      row_data,
  output logic             cursor_cell,
  output logic [POP_W-1:0] population,
  output logic [GEN_W-1:0] generation,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, CALC, COMMIT} state_t;

  state_t           state;
  logic [15:0]      map [16];
  logic [15:0]      nxt [16];
  logic [3:0]       r;
  logic [POP_W-1:0] acc;
  logic             pend;
  logic [3:0]       px, py;

  logic [15:0]      up, mid, dn;
  logic [15:0]      calc_row;
  logic [POP_W-1:0] row_pop;
  logic [3:0]       n;
  logic             tg_do;
  logic [3:0]       tx, ty;
  logic             tcell;

  // Next-state row r from its three source rows; 4-bit index arithmetic gives the torus wrap.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    up       = map[r - 4'd1];
    mid      = map[r];
    dn       = map[r + 4'd1];
    calc_row = '0;
    row_pop  = '0;
    n        = '0;
    for (int x = 0; x < 16; x++) begin
      n = 4'(up[(x + 15) % 16]) + 4'(up[x]) + 4'(up[(x + 1) % 16]) +
          4'(mid[(x + 15) % 16]) + 4'(mid[(x + 1) % 16]) +
          4'(dn[(x + 15) % 16]) + 4'(dn[x]) + 4'(dn[(x + 1) % 16]);
      calc_row[x] = mid[x] ? (n == 4'd2 || n == 4'd3) : (n == 4'd3);
      row_pop     = row_pop + POP_W'(calc_row[x]);
    end
  end

  // A fresh toggle overrides one left pending from the busy period.
  always_comb begin
    tg_do = toggle | pend;
    tx    = toggle ? cursor_x : px;
    ty    = toggle ? cursor_y : py;
    tcell = map[ty][tx];
  end

  // NOTE: the map is reset explicitly because a zero board after reset is observable
  // behaviour; a plain RAM without reset would power up with random cells.
  // NOTE: all sequential state uses non-blocking assignments so every register samples
  // pre-edge values and the evaluation order of the statements cannot matter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      r          <= '0;
      acc        <= '0;
      population <= '0;
      generation <= '0;
      pend       <= 1'b0;
      px         <= '0;
      py         <= '0;
      for (int i = 0; i < 16; i++) begin
        map[i] <= '0;
        nxt[i] <= '0;
      end
    end else begin
      if (state != IDLE && toggle) begin
        pend <= 1'b1;
        px   <= cursor_x;
        py   <= cursor_y;
      end
      case (state)
        IDLE: begin
          if (clear) begin
            for (int i = 0; i < 16; i++) map[i] <= '0;
            population <= '0;
            generation <= '0;
            pend       <= 1'b0;
          end else if (tg_do) begin
            map[ty][tx] <= ~tcell;
            population  <= tcell ? population - POP_W'(1) : population + POP_W'(1);
            pend        <= 1'b0;
          end else if (step) begin
            r     <= '0;
            acc   <= '0;
            state <= CALC;
          end
        end
        CALC: begin
          nxt[r] <= calc_row;
          acc    <= acc + row_pop;
          r      <= r + 4'd1;
          if (r == 4'd15) state <= COMMIT;
        end
        COMMIT: begin
          for (int i = 0; i < 16; i++) map[i] <= nxt[i];
          population <= acc;
          generation <= generation + GEN_W'(1);
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy        = (state != IDLE);
  assign row_data    = map[rd_row];
  assign cursor_cell = map[cursor_y][cursor_x];

endmodule

// File: tb/tb_life_engine.sv
// Scoreboard bench for life_engine: stimulus queues expectations, a monitor checks them
// at each busy falling edge (generation result) and on explicit sample requests.
`timescale 1ns/1ps
module tb_life_engine;
  localparam int GEN_W = 16;
  localparam int POP_W = 9;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             step = 1'b0, toggle = 1'b0, clear = 1'b0;
  logic [3:0]       cursor_x = '0, cursor_y = '0, rd_row = '0;
  logic [15:0]      row_data;
  logic             cursor_cell;
  logic [POP_W-1:0] population;
  logic [GEN_W-1:0] generation;
  logic             busy;

  life_engine #(.GEN_W(GEN_W), .POP_W(POP_W)) dut (
    .clk(clk), .rst_n(rst_n), .step(step), .toggle(toggle), .clear(clear),
    .cursor_x(cursor_x), .cursor_y(cursor_y), .rd_row(rd_row),
    .row_data(row_data), .cursor_cell(cursor_cell), .population(population),
    .generation(generation), .busy(busy)
  );

  always #10 clk = ~clk;

  typedef enum int {S_ROW, S_CELL, S_POP, S_GEN, S_BUSY} sel_t;
  typedef struct {string name; sel_t sel; int idx; logic [31:0] val;} samp_t;
  typedef struct {int len; int pop; int gen;} gen_t;

  samp_t       samp_q[$];
  gen_t        gen_q[$];
  int          tests = 0, fails = 0;
  bit          sample_req = 1'b0;
  logic [15:0] exp_map [16];
  int          exp_gen = 0;

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic push_samp(input string name, input sel_t sel, input int idx,
                           input logic [31:0] val);
    samp_t s;
    s.name = name; s.sel = sel; s.idx = idx; s.val = val;
    samp_q.push_back(s);
  endtask

  task automatic push_map();
    for (int i = 0; i < 16; i++) push_samp("row", S_ROW, i, 32'(exp_map[i]));
  endtask

  task automatic map_zero();
    for (int i = 0; i < 16; i++) exp_map[i] = '0;
  endtask

  task automatic push_status(input int pop, input int gen);
    push_samp("population", S_POP, 0, 32'(pop));
    push_samp("generation", S_GEN, 0, 32'(gen));
    push_samp("busy", S_BUSY, 0, 32'(0));
  endtask

  // Hand the queued samples to the monitor and wait until it has consumed them.
  task automatic request();
    sample_req = 1'b1;
    while (sample_req) @(posedge clk);
    #1;
  endtask

  task automatic do_toggle(input int x, input int y);
    cursor_x = 4'(x); cursor_y = 4'(y); toggle = 1'b1;
    @(posedge clk); #1;
    toggle = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    exp_gen = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy === 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 40) check("wait_idle_timeout", 0, 32'(busy), 32'(0));
  endtask

  task automatic do_step(input int pop);
    gen_t g;
    exp_gen++;
    g.len = 17; g.pop = pop; g.gen = exp_gen;
    gen_q.push_back(g);
    step = 1'b1;
    @(posedge clk); #1;
    step = 1'b0;
    wait_idle();
  endtask

  // Monitor: generation results on each busy falling edge, samples on request.
  initial begin
    int    run;
    bit    prev;
    gen_t  g;
    samp_t s;
    run = 0; prev = 1'b0;
    forever begin
      @(negedge clk);
      if (busy) run++;
      else if (prev) begin
        if (gen_q.size() == 0) check("unexpected_gen", 0, 32'(1), 32'(0));
        else begin
          g = gen_q.pop_front();
          check("busy_len", g.gen, 32'(run), 32'(g.len));
          check("gen_pop", g.gen, 32'(population), 32'(g.pop));
          check("gen_count", g.gen, 32'(generation), 32'(g.gen));
        end
        run = 0;
      end
      prev = busy;
      if (sample_req) begin
        while (samp_q.size() > 0) begin
          s = samp_q.pop_front();
          case (s.sel)
            S_ROW: begin
              rd_row = 4'(s.idx);
              #0.5;
              check(s.name, s.idx, 32'(row_data), s.val);
            end
            S_CELL: check(s.name, s.idx, 32'(cursor_cell), s.val);
            S_POP:  check(s.name, s.idx, 32'(population), s.val);
            S_GEN:  check(s.name, s.idx, 32'(generation), s.val);
            default: check(s.name, s.idx, 32'(busy), s.val);
          endcase
        end
        sample_req = 1'b0;
      end
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    gen_t g;
    // 1: reset state, toggle on/off at (0,0)
    repeat (2) @(posedge clk);
    #1;
    map_zero(); push_map(); push_status(0, 0);
    push_samp("reset_cell", S_CELL, 0, 32'(0));
    request();
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_toggle(0, 0);
    push_samp("row0_on", S_ROW, 0, 32'h0001);
    push_samp("pop_on", S_POP, 0, 32'(1));
    push_samp("cell_on", S_CELL, 0, 32'(1));
    request();
    do_toggle(0, 0);
    push_samp("row0_off", S_ROW, 0, 32'h0000);
    push_samp("pop_off", S_POP, 0, 32'(0));
    push_samp("cell_off", S_CELL, 0, 32'(0));
    request();

    // 2: blinker oscillates horizontal <-> vertical
    do_toggle(6, 7); do_toggle(7, 7); do_toggle(8, 7);
    map_zero(); exp_map[7] = 16'h01C0; push_map(); push_status(3, 0);
    request();
    do_step(3);
    map_zero(); exp_map[6] = 16'h0080; exp_map[7] = 16'h0080; exp_map[8] = 16'h0080;
    push_map(); push_status(3, 1);
    request();
    do_step(3);
    map_zero(); exp_map[7] = 16'h01C0; push_map(); push_status(3, 2);
    request();
    do_clear();
    map_zero(); push_map(); push_status(0, 0);
    request();

    // 3: 2x2 block split across all four corners is still life on the torus
    do_toggle(0, 0); do_toggle(15, 0); do_toggle(0, 15); do_toggle(15, 15);
    for (int i = 0; i < 5; i++) do_step(4);
    map_zero(); exp_map[0] = 16'h8001; exp_map[15] = 16'h8001; push_map(); push_status(4, 5);
    request();
    do_clear();

    // 4: glider travels 16 cells diagonally in 64 generations, back to origin
    do_toggle(1, 0); do_toggle(2, 1); do_toggle(0, 2); do_toggle(1, 2); do_toggle(2, 2);
    for (int i = 0; i < 64; i++) do_step(5);
    map_zero(); exp_map[0] = 16'h0002; exp_map[1] = 16'h0004; exp_map[2] = 16'h0007;
    push_map(); push_status(5, 64);
    request();

    // clear and toggle together: clear wins
    cursor_x = 4'd5; cursor_y = 4'd5; clear = 1'b1; toggle = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; toggle = 1'b0; exp_gen = 0;
    map_zero(); push_map(); push_status(0, 0);
    push_samp("clr_tog_cell", S_CELL, 5, 32'(0));
    request();

    // 5: step held through the whole busy period, toggle latched mid-CALC
    do_toggle(6, 7); do_toggle(7, 7); do_toggle(8, 7);
    g.len = 17; g.pop = 3; g.gen = 1;
    gen_q.push_back(g);
    exp_gen = 1;
    step = 1'b1;
    @(posedge clk);
    repeat (5) @(posedge clk);
    #1;
    toggle = 1'b1; cursor_x = 4'd3; cursor_y = 4'd3;
    @(posedge clk); #1;
    toggle = 1'b0; cursor_x = 4'd10; cursor_y = 4'd10;
    repeat (11) @(posedge clk);
    #1;
    step = 1'b0;
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    cursor_x = 4'd3; cursor_y = 4'd3;
    map_zero(); exp_map[3] = 16'h0008;
    exp_map[6] = 16'h0080; exp_map[7] = 16'h0080; exp_map[8] = 16'h0080;
    push_map(); push_status(4, 1);
    push_samp("pend_cell", S_CELL, 3, 32'(1));
    request();

    // 6: reset during CALC cycle 8 clears everything, including a pending toggle
    g.len = 8; g.pop = 0; g.gen = 0;
    gen_q.push_back(g);
    step = 1'b1;
    @(posedge clk); #1;
    step = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    toggle = 1'b1; cursor_x = 4'd9; cursor_y = 4'd9;
    @(posedge clk); #1;
    toggle = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_gen = 0;
    map_zero(); push_map(); push_status(0, 0);
    request();
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    push_samp("post_rst_row9", S_ROW, 9, 32'h0000);
    push_samp("post_rst_cell", S_CELL, 9, 32'(0));
    push_status(0, 0);
    request();

    repeat (4) @(posedge clk);
    #1;
    check("gen_q_left", 0, 32'(gen_q.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
